// File: rtl/mul_seq_pkg.sv
// Shared arithmetic-unit constants: FSM encoding and default width.
// Imported by the multiplier and the restoring divider.
package mul_seq_pkg;

    localparam int W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int step_bits(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Operand/result bundle between the arithmetic unit and its client.
// The client drives ld/a/b, the unit returns the register view.
interface mul_seq_if #(
    parameter int W = mul_seq_pkg::W
);

    logic           ld;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] ra;
    logic [2*W-1:0] rb;
    logic [W-1:0]   ry;
    logic           busy;
    logic           done;

    modport master (
        output ld, a, b,
        input  ra, rb, ry, busy, done
    );

    modport slave (
        input  ld, a, b,
        output ra, rb, ry, busy, done
    );

endinterface

// File: rtl/mul_seq_dp.sv
// Shift-and-add datapath: accumulator, shifted multiplicand,
// remaining multiplier bits. Sequenced by load/step strobes.
module mul_seq_dp #(
    parameter int W = mul_seq_pkg::W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           stp,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] ra,
    output logic [2*W-1:0] rb,
    output logic [W-1:0]   ry
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ra <= '0;
            rb <= '0;
            ry <= '0;
        end else if (load) begin
            ra <= '0;
            rb <= {{W{1'b0}}, a};
            ry <= b;
        end else if (stp) begin
            // 2W-bit accumulator cannot overflow for W-bit operands
            if (ry[0]) begin
                ra <= ra + rb;
            end
            rb <= rb << 1;
            ry <= ry >> 1;
        end
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier: fixed W-step FSM around mul_seq_dp.
// One operation in flight; ld is ignored while running.
module mul_seq #(
    parameter int W = mul_seq_pkg::W
) (
    input  logic      clk,
    input  logic      rst,
    mul_seq_if.slave  bus
);

    import mul_seq_pkg::*;

    localparam int SW = $clog2(W) + 1;

    logic [1:0]    state;
    logic [SW-1:0] step;
    logic          load;
    logic          stp;
    logic          last;

    assign load = bus.ld && (state != ST_RUN);
    assign stp  = (state == ST_RUN);
    assign last = (step == SW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ld) begin
                        state <= ST_RUN;
                        step  <= '0;
                    end
                end
                ST_RUN: begin
                    step <= step + 1'b1;
                    if (last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // back-to-back restart skips IDLE
                    if (bus.ld) begin
                        state <= ST_RUN;
                        step  <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    step  <= '0;
                end
            endcase
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);

    mul_seq_dp #(
        .W(W)
    ) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .stp  (stp),
        .a    (bus.a),
        .b    (bus.b),
        .ra   (bus.ra),
        .rb   (bus.rb),
        .ry   (bus.ry)
    );

endmodule
